median_scan_ctrl: RTL and testbench

//  Parametrised scan controller for the median filter datapath. It sequences one frame:
//   - waits for the input image to load;
//   - steps the filter window over every window position, handshaking with the filter and the result memory;
//   - streams every output pixel address to the file writer using valid/ready.
//  It supersedes the fixed 430x554 / 3x3 controller and adds a border mode, a dump handshake, a clear and a reset.

---
 rtl/median_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_median_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_scan_ctrl.sv
// rtl/median_scan_ctrl.sv - frame scan controller for the median filter datapath
// Sequences image load wait, window-by-window filtering and the output address dump.
module median_scan_ctrl #(
  parameter int IMG_W = 430,
  parameter int IMG_H = 554,
  parameter int WIN   = 3,
  localparam int CW   = $clog2(IMG_W),
  localparam int RW   = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic          mode,
  input  logic          input_done,
  input  logic          filter_done,
  input  logic          wr_ack,
  input  logic          out_ready,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          enable_filter,
  output logic          rw,
  output logic          out_valid,
  output logic          finish,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_FILTER  = 3'd2,
    S_ADVANCE = 3'd3,
    S_DUMP    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_VALID = CW'(IMG_W - WIN);
  localparam logic [RW-1:0] ROW_VALID = RW'(IMG_H - WIN);

  state_t        st_q, st_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          m_q, m_d;
  logic [CW-1:0] col_last;
  logic [RW-1:0] row_last;

  // Full-frame mode anchors the window on every pixel; the filter replicates borders.
  assign col_last = m_q ? COL_MAX : COL_VALID;
  assign row_last = m_q ? ROW_MAX : ROW_VALID;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      col_q <= '0;
      row_q <= '0;
      m_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      col_q <= col_d;
      row_q <= row_d;
      m_q   <= m_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    col_d = col_q;
    row_d = row_q;
    m_d   = m_q;
    if (clear) begin
      st_d  = S_IDLE;
      col_d = '0;
      row_d = '0;
      m_d   = 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (start) begin
            st_d = S_WAIT_IN;
            m_d  = mode;
          end
        end
        S_WAIT_IN: begin
          if (start && input_done) begin
            st_d  = S_FILTER;
            col_d = '0;
            row_d = '0;
          end
        end
        S_FILTER: begin
          if (start && filter_done) st_d = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (start && wr_ack) begin
            st_d = S_FILTER;
            if (col_q < col_last) begin
              col_d = col_q + CW'(1);
            end else if (row_q < row_last) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = '0;
              row_d = '0;
              st_d  = S_DUMP;
            end
          end
        end
        S_DUMP: begin
          // Address holds until accepted; the last pixel stays put on entry to DONE.
          if (start && out_ready) begin
            if (col_q < COL_MAX) begin
              col_d = col_q + CW'(1);
            end else if (row_q < ROW_MAX) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              st_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!start) begin
            st_d  = S_IDLE;
            col_d = '0;
            row_d = '0;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  assign col           = col_q;
  assign row           = row_q;
  assign state         = st_q;
  assign enable_filter = (st_q == S_FILTER);
  assign rw            = (st_q == S_FILTER);
  assign out_valid     = (st_q == S_DUMP);
  assign finish        = (st_q == S_DONE);

endmodule

// File: tb/tb_median_scan_ctrl.sv
// tb/tb_median_scan_ctrl.sv - scoreboard bench for median_scan_ctrl
// Expected window anchors and dump addresses are queued up front and popped as the DUT presents them.
module tb_median_scan_ctrl;

  localparam int W = 5;
  localparam int H = 4;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic       input_done = 1'b0;
  logic       filter_done = 1'b0;
  logic       wr_ack = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] col;
  logic [1:0] row;
  logic       enable_filter;
  logic       rw;
  logic       out_valid;
  logic       finish;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int q_win[$];
  int q_dump[$];

  median_scan_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .input_done(input_done), .filter_done(filter_done), .wr_ack(wr_ack),
    .out_ready(out_ready), .col(col), .row(row), .enable_filter(enable_filter),
    .rw(rw), .out_valid(out_valid), .finish(finish), .state(state)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    input_done = 1'b0; filter_done = 1'b0; wr_ack = 1'b0; out_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic goto_filter(input logic md);
    bit ok = 0;
    mode = md;
    start = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      input_done = (state == 3'd1);
      if (state == 3'd2) ok = 1;
    end
    input_done = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL goto_filter: state=%0d required=2", state); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      total++;
      if ({state, col, row, enable_filter, rw, out_valid, finish} !== 12'd0) begin
        bad++;
        $display("FAIL reset_idle: cyc=%0d state=%0d col=%0d row=%0d ef=%b rw=%b ov=%b fin=%b required all 0",
                 n, state, col, row, enable_filter, rw, out_valid, finish);
      end
    end
    goto_filter(1'b0);
    total++;
    if (enable_filter !== 1'b1 || rw !== 1'b1) begin
      bad++; $display("FAIL filter_outputs: ef=%b rw=%b required 1 1", enable_filter, rw);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({state, col, row, enable_filter, rw, out_valid, finish} !== 12'd0) begin
      bad++;
      $display("FAIL async_reset: state=%0d ef=%b rw=%b required 0 0 0", state, enable_filter, rw);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one frame; abort_c >= 0 clears the controller when that dump address is presented.
  task automatic run_frame(input logic md, input bit toggle, input int exp_win,
                           input int abort_c, input int abort_r);
    int   cl, rl, cyc, visits, dcyc, exp;
    logic [2:0] st, prev;
    bit   ph, done, aborted;
    q_win.delete();
    q_dump.delete();
    cl = md ? W - 1 : W - K;
    rl = md ? H - 1 : H - K;
    for (int r = 0; r <= rl; r++) for (int c = 0; c <= cl; c++) q_win.push_back(r * 100 + c);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) q_dump.push_back(r * 100 + c);
    idle_inputs();
    mode = md;
    start = 1'b1;
    prev = 3'd0; cyc = 0; visits = 0; dcyc = 0; ph = 0; done = 0; aborted = 0;
    for (int n = 0; n < 2000 && !done && !aborted; n++) begin
      @(negedge clk);
      st = state;
      cyc = (st == prev) ? cyc + 1 : 0;
      out_ready = 1'b0;
      if (st == 3'd2 && cyc == 0) begin
        visits++;
        exp = (q_win.size() > 0) ? q_win.pop_front() : -1;
        total++;
        if (int'(row) * 100 + int'(col) !== exp) begin
          bad++; $display("FAIL window_anchor: got (%0d,%0d) required code %0d", col, row, exp);
        end
      end
      if (st == 3'd4) begin
        dcyc++;
        exp = (q_dump.size() > 0) ? q_dump[0] : -1;
        total++;
        if (int'(row) * 100 + int'(col) !== exp || out_valid !== 1'b1 || rw !== 1'b0) begin
          bad++; $display("FAIL dump_addr: got (%0d,%0d) ov=%b rw=%b required code %0d ov=1 rw=0",
                          col, row, out_valid, rw, exp);
        end
        if (abort_c >= 0 && int'(col) == abort_c && int'(row) == abort_r) begin
          clear = 1'b1;
          aborted = 1;
        end else begin
          out_ready = toggle ? ph : 1'b1;
          ph = ~ph;
          if (out_ready && q_dump.size() > 0) void'(q_dump.pop_front());
        end
      end
      input_done  = (st == 3'd1);
      filter_done = (st == 3'd2 && cyc >= 1);
      wr_ack      = (st == 3'd3 && cyc >= 1);
      if (st == 3'd5) done = 1;
      prev = st;
    end
    if (aborted) begin
      @(negedge clk);
      total++;
      if ({state, col, row, enable_filter, rw, out_valid, finish} !== 12'd0) begin
        bad++; $display("FAIL clear_dump: state=%0d col=%0d row=%0d ov=%b required all 0",
                        state, col, row, out_valid);
      end
      idle_inputs();
      start = 1'b0;
      @(negedge clk);
      return;
    end
    idle_inputs();
    total++;
    if (!done) begin bad++; $display("FAIL frame_timeout: state=%0d required 5", state); end
    total++;
    if (finish !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL done_outputs: fin=%b ov=%b required 1 0", finish, out_valid);
    end
    total++;
    if (visits !== exp_win || q_win.size() !== 0) begin
      bad++; $display("FAIL window_count: got %0d left %0d required %0d", visits, q_win.size(), exp_win);
    end
    total++;
    if (q_dump.size() !== 0) begin bad++; $display("FAIL dump_count: left %0d required 0", q_dump.size()); end
    if (toggle) begin
      total++;
      if (dcyc !== 40) begin bad++; $display("FAIL dump_cycles: got %0d required 40", dcyc); end
    end
    repeat (2) @(negedge clk);
    total++;
    if (finish !== 1'b1) begin bad++; $display("FAIL done_hold: fin=%b required 1", finish); end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || finish !== 1'b0 || col !== 3'd0 || row !== 2'd0) begin
      bad++; $display("FAIL done_exit: state=%0d fin=%b col=%0d row=%0d required 0 0 0 0",
                      state, finish, col, row);
    end
  endtask

  task automatic test_valid_mode();  run_frame(1'b0, 1'b0, 6, -1, 0);  endtask
  task automatic test_full_mode();   run_frame(1'b1, 1'b0, 20, -1, 0); endtask
  task automatic test_dump_toggle(); run_frame(1'b1, 1'b1, 20, -1, 0); endtask
  task automatic test_clear_dump();  run_frame(1'b0, 1'b0, 6, 2, 1);   endtask

  task automatic test_freeze();
    bit ok = 0;
    idle_inputs();
    goto_filter(1'b0);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      filter_done = (n == 1);
      @(negedge clk);
      total++;
      if (state !== 3'd2 || enable_filter !== 1'b1 || col !== 3'd0 || row !== 2'd0) begin
        bad++; $display("FAIL freeze_hold: cyc=%0d state=%0d ef=%b required 2 1", n, state, enable_filter);
      end
    end
    filter_done = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL pulse_lost: state=%0d required 2", state); end
    filter_done = 1'b1;
    for (int n = 0; n < 5 && !ok; n++) begin
      @(negedge clk);
      if (state == 3'd3) ok = 1;
    end
    total++;
    if (!ok || enable_filter !== 1'b0) begin
      bad++; $display("FAIL resume_advance: state=%0d ef=%b required 3 0", state, enable_filter);
    end
    idle_inputs();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL freeze_clear: state=%0d required 0", state); end
  endtask

  initial begin
    test_reset();
    test_valid_mode();
    test_full_mode();
    test_dump_toggle();
    test_freeze();
    test_clear_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
